// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Result is registered once and returned on a tagged valid/ready channel.
package alu_arbiter_pkg;
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_XOR  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_AND  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_t;
endpackage

module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  alu_op_t          req0_op,
    input  logic             req0_is_imm,
    input  logic [31:0]      req0_rs1,
    input  logic [31:0]      req0_rs2,
    input  logic [31:0]      req0_imm,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  alu_op_t          req1_op,
    input  logic             req1_is_imm,
    input  logic [31:0]      req1_rs1,
    input  logic [31:0]      req1_rs2,
    input  logic [31:0]      req1_imm,
    input  logic [TAG_W-1:0] req1_tag,
    output alu_op_t          alu_op,
    output logic             alu_is_imm,
    output logic [31:0]      alu_rs1,
    output logic [31:0]      alu_rs2,
    output logic [31:0]      alu_imm,
    input  logic [31:0]      alu_rd,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_data,
    output logic             resp_id,
    output logic [TAG_W-1:0] resp_tag
);

    logic             last_grant_q, last_grant_d;
    logic             resp_valid_q, resp_valid_d;
    logic [31:0]      resp_data_q, resp_data_d;
    logic             resp_id_q, resp_id_d;
    logic [TAG_W-1:0] resp_tag_q, resp_tag_d;

    logic slot_free;
    logic gnt0;
    logic gnt1;

    // Grant: a single valid port wins; on contention the port not last granted wins.
    always_comb begin
        slot_free = !resp_valid_q || resp_ready;
        gnt0 = slot_free && req0_valid && (!req1_valid || last_grant_q);
        gnt1 = slot_free && req1_valid && (!req0_valid || !last_grant_q);
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    // Operand mux: port 0 fields by default so the ALU never sees X when idle.
    always_comb begin
        alu_op     = req0_op;
        alu_is_imm = req0_is_imm;
        alu_rs1    = req0_rs1;
        alu_rs2    = req0_rs2;
        alu_imm    = req0_imm;
        if (gnt1) begin
            alu_op     = req1_op;
            alu_is_imm = req1_is_imm;
            alu_rs1    = req1_rs1;
            alu_rs2    = req1_rs2;
            alu_imm    = req1_imm;
        end
    end

    // Next state: drain clears valid, an accept overwrites the result slot.
    always_comb begin
        last_grant_d = last_grant_q;
        resp_valid_d = resp_valid_q && !resp_ready;
        resp_data_d  = resp_data_q;
        resp_id_d    = resp_id_q;
        resp_tag_d   = resp_tag_q;
        if (gnt0 || gnt1) begin
            last_grant_d = gnt1;
            resp_valid_d = 1'b1;
            resp_data_d  = alu_rd;
            resp_id_d    = gnt1;
            resp_tag_d   = gnt1 ? req1_tag : req0_tag;
        end
    end

    // State register; last_grant resets to 1 so port 0 wins first contention.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_id_q    <= 1'b0;
            resp_tag_q   <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_id_q    <= resp_id_d;
            resp_tag_q   <= resp_tag_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_id    = resp_id_q;
    assign resp_tag   = resp_tag_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed testbench for alu_arbiter with a behavioural ALU model.
// Expected values are hand-computed constants.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0_valid, req0_ready, req0_is_imm;
    alu_op_t          req0_op;
    logic [31:0]      req0_rs1, req0_rs2, req0_imm;
    logic [TAG_W-1:0] req0_tag;
    logic             req1_valid, req1_ready, req1_is_imm;
    alu_op_t          req1_op;
    logic [31:0]      req1_rs1, req1_rs2, req1_imm;
    logic [TAG_W-1:0] req1_tag;
    alu_op_t          alu_op;
    logic             alu_is_imm;
    logic [31:0]      alu_rs1, alu_rs2, alu_imm, alu_rd;
    logic             resp_valid, resp_ready, resp_id;
    logic [31:0]      resp_data;
    logic [TAG_W-1:0] resp_tag;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_op(req0_op), .req0_is_imm(req0_is_imm),
        .req0_rs1(req0_rs1), .req0_rs2(req0_rs2),
        .req0_imm(req0_imm), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_op(req1_op), .req1_is_imm(req1_is_imm),
        .req1_rs1(req1_rs1), .req1_rs2(req1_rs2),
        .req1_imm(req1_imm), .req1_tag(req1_tag),
        .alu_op(alu_op), .alu_is_imm(alu_is_imm),
        .alu_rs1(alu_rs1), .alu_rs2(alu_rs2),
        .alu_imm(alu_imm), .alu_rd(alu_rd),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_id(resp_id), .resp_tag(resp_tag)
    );

    // Behavioural ALU standing in for the core's datapath
    always_comb begin
        logic [31:0] b;
        b = alu_is_imm ? alu_imm : alu_rs2;
        case (alu_op)
            ALU_ADD: alu_rd = alu_rs1 + b;
            ALU_SUB: alu_rd = alu_rs1 - b;
            ALU_XOR: alu_rd = alu_rs1 ^ b;
            ALU_OR:  alu_rd = alu_rs1 | b;
            ALU_AND: alu_rd = alu_rs1 & b;
            default: alu_rd = 32'd0;
        endcase
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk_resp(input string tag, input logic v,
                            input logic [31:0] d, input logic id,
                            input logic [TAG_W-1:0] t);
        chk({tag, ".valid"}, 64'(resp_valid), 64'(v));
        chk({tag, ".data"}, 64'(resp_data), 64'(d));
        chk({tag, ".id"}, 64'(resp_id), 64'(id));
        chk({tag, ".tag"}, 64'(resp_tag), 64'(t));
    endtask

    task automatic chk_rdy(input string tag, input logic r0, input logic r1);
        chk({tag, ".rdy0"}, 64'(req0_ready), 64'(r0));
        chk({tag, ".rdy1"}, 64'(req1_ready), 64'(r1));
    endtask

    task automatic set0(input logic v, input alu_op_t op, input logic im,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] i, input logic [TAG_W-1:0] t);
        req0_valid = v; req0_op = op; req0_is_imm = im;
        req0_rs1 = a; req0_rs2 = b; req0_imm = i; req0_tag = t;
    endtask

    task automatic set1(input logic v, input alu_op_t op, input logic im,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] i, input logic [TAG_W-1:0] t);
        req1_valid = v; req1_op = op; req1_is_imm = im;
        req1_rs1 = a; req1_rs2 = b; req1_imm = i; req1_tag = t;
    endtask

    initial begin
        rst = 1'b1;
        resp_ready = 1'b0;
        set0(1'b0, ALU_ADD, 1'b0, 32'd0, 32'd0, 32'd0, 4'd0);
        set1(1'b0, ALU_ADD, 1'b0, 32'd0, 32'd0, 32'd0, 4'd0);
        cyc();
        cyc();
        rst = 1'b0;
        chk_resp("reset", 1'b0, 32'd0, 1'b0, 4'd0);

        // Single op
        set0(1'b1, ALU_ADD, 1'b0, 32'd5, 32'd7, 32'd0, 4'd3);
        settle();
        chk_rdy("single", 1'b1, 1'b0);
        cyc();
        req0_valid = 1'b0;
        chk_resp("single.r", 1'b1, 32'd12, 1'b0, 4'd3);
        resp_ready = 1'b1;
        cyc();
        chk_resp("drain", 1'b0, 32'd12, 1'b0, 4'd3);

        // Contention from a fresh reset
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        set0(1'b1, ALU_SUB, 1'b0, 32'd10, 32'd4, 32'd0, 4'd1);
        set1(1'b1, ALU_XOR, 1'b0, 32'hF0, 32'h0F, 32'd0, 4'd2);
        for (int i = 0; i < 4; i++) begin
            settle();
            chk_rdy($sformatf("cont%0d", i), i % 2 == 0, i % 2 == 1);
            cyc();
            if (i % 2 == 0)
                chk_resp($sformatf("cont%0d.r", i), 1'b1, 32'd6, 1'b0, 4'd1);
            else
                chk_resp($sformatf("cont%0d.r", i), 1'b1, 32'hFF, 1'b1, 4'd2);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        cyc();
        chk("cont.drain", 64'(resp_valid), 64'd0);

        // Backpressure
        resp_ready = 1'b0;
        set1(1'b1, ALU_ADD, 1'b1, 32'd100, 32'd0, 32'hFFFF_FFFF, 4'd5);
        settle();
        chk_rdy("bp.acc", 1'b0, 1'b1);
        cyc();
        req1_valid = 1'b0;
        set0(1'b1, ALU_AND, 1'b0, 32'hFF, 32'h0F, 32'd0, 4'd6);
        for (int i = 0; i < 3; i++) begin
            settle();
            chk_rdy($sformatf("bp%0d", i), 1'b0, 1'b0);
            chk_resp($sformatf("bp%0d", i), 1'b1, 32'd99, 1'b1, 4'd5);
            cyc();
        end
        chk_resp("bp.hold", 1'b1, 32'd99, 1'b1, 4'd5);
        resp_ready = 1'b1;
        settle();
        chk_rdy("bp.release", 1'b1, 1'b0);
        cyc();
        req0_valid = 1'b0;
        chk_resp("bp.next", 1'b1, 32'h0F, 1'b0, 4'd6);
        cyc();

        // Priority hold across idle cycles
        set1(1'b1, ALU_ADD, 1'b0, 32'd1, 32'd2, 32'd0, 4'd7);
        cyc();
        req1_valid = 1'b0;
        chk_resp("prio.r1", 1'b1, 32'd3, 1'b1, 4'd7);
        for (int i = 0; i < 4; i++) cyc();
        chk("prio.idle", 64'(resp_valid), 64'd0);
        set0(1'b1, ALU_SUB, 1'b0, 32'd10, 32'd4, 32'd0, 4'd1);
        set1(1'b1, ALU_XOR, 1'b0, 32'hF0, 32'h0F, 32'd0, 4'd2);
        settle();
        chk_rdy("prio.both", 1'b1, 1'b0);
        cyc();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk_resp("prio.r", 1'b1, 32'd6, 1'b0, 4'd1);
        cyc();

        // Reset mid-flight
        set0(1'b1, ALU_OR, 1'b0, 32'h3, 32'h4, 32'd0, 4'd9);
        cyc();
        req0_valid = 1'b0;
        chk_resp("rstmf.acc", 1'b1, 32'h7, 1'b0, 4'd9);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk_resp("rstmf", 1'b0, 32'd0, 1'b0, 4'd0);
        set0(1'b1, ALU_SUB, 1'b0, 32'd10, 32'd4, 32'd0, 4'd1);
        set1(1'b1, ALU_XOR, 1'b0, 32'hF0, 32'h0F, 32'd0, 4'd2);
        settle();
        chk_rdy("rstmf.both", 1'b1, 1'b0);
        cyc();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk_resp("rstmf.r", 1'b1, 32'd6, 1'b0, 4'd1);
        cyc();

        // Valid withdrawal while slot is full
        resp_ready = 1'b0;
        set1(1'b1, ALU_ADD, 1'b0, 32'd1, 32'd2, 32'd0, 4'd7);
        cyc();
        req1_valid = 1'b0;
        set0(1'b1, ALU_ADD, 1'b0, 32'd8, 32'd8, 32'd0, 4'd4);
        settle();
        chk_rdy("wd.full", 1'b0, 1'b0);
        cyc();
        req0_valid = 1'b0;
        chk_resp("wd.hold", 1'b1, 32'd3, 1'b1, 4'd7);
        resp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk($sformatf("wd.noid0_%0d", i),
                64'(resp_valid && resp_id == 1'b0), 64'd0);
        end
        chk("wd.empty", 64'(resp_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the core's single combinational ALU between two requesters:
  - port 0: integer execute stage.
  - port 1: address-generation / branch-compare path.
- Each port uses a valid/ready request handshake.
- Grants one request per cycle with round-robin fairness, drives the ALU operand/op inputs, and registers the ALU result.
- Returns the result on one tagged response channel with backpressure.

Parameters:
- TAG_W, 4, width of requester-supplied tag echoed with the result.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req0_valid  in  1  port 0 request valid.
- req0_ready  out  1  port 0 request accepted this cycle.
- req0_op  in  alu_op_t  port 0 ALU operation.
- req0_is_imm  in  1  port 0 immediate select.
- req0_rs1  in  32  port 0 operand 1.
- req0_rs2  in  32  port 0 operand 2.
- req0_imm  in  32  port 0 I-type immediate.
- req0_tag  in  TAG_W  port 0 tag.
- req1_*  in/out  same as req0_*  port 1 request (valid, ready, op, is_imm, rs1, rs2, imm, tag).
- alu_op  out  alu_op_t  to ALU.
- alu_is_imm  out  1  to ALU.
- alu_rs1  out  32  to ALU.
- alu_rs2  out  32  to ALU.
- alu_imm  out  32  to ALU.
- alu_rd  in  32  ALU result, combinational from the alu_* outputs.
- resp_valid  out  1  result register holds a result.
- resp_ready  in  1  consumer accepts the result.
- resp_data  out  32  registered ALU result.
- resp_id  out  1  requester index that produced resp_data.
- resp_tag  out  TAG_W  tag of that request.

Behaviour:
- Reset: synchronous, active-high, on clk rising edge.
  - resp_valid=0, resp_data=0, resp_id=0, resp_tag=0.
  - last_grant=1, so port 0 wins the first contention.
  - A request in flight during reset is discarded; no response is produced.
- Slot free: slot_free = !resp_valid || resp_ready. There is one result register, with no further buffering.
- Grant, combinational each cycle, only when slot_free:
  - Only one port valid: grant that port.
  - Both valid: grant port != last_grant.
  - slot_free=0: no grant; req0_ready=req1_ready=0.
- reqN_ready = slot_free && grant==N. Ready never depends on reqN_ready of the other port. At most one ready per cycle.
- ALU drive: alu_* = fields of the granted port. With no grant, alu_* = port 0 fields (don't-care, but must be deterministic with no X).
- Accept at a cycle edge where reqN_valid && reqN_ready:
  - resp_data<=alu_rd, resp_id<=N, resp_tag<=reqN_tag, resp_valid<=1, last_grant<=N.
- Latency: result appears on resp_* exactly 1 cycle after acceptance.
- Drain: resp_valid && resp_ready with no accept in the same cycle → resp_valid<=0. Data/id/tag hold their last value.
- Simultaneous drain and accept: the new result overwrites the register and resp_valid stays 1. Full throughput is 1 op/cycle.
- Backpressure: while resp_valid && !resp_ready, resp_* are held stable and no request is accepted.
- last_grant changes only on an accepted grant. Idle cycles and stalls never rotate priority.
- Fairness: under continuous contention, grants alternate 0,1,0,1. A waiting valid port is granted within 2 accepts.
- Requester rule: reqN fields must stay stable while valid && !ready. The arbiter must tolerate valid dropping without acceptance and must never accept a request whose valid is low.
- Widths: all data is 32-bit pass-through. No arithmetic is performed in this block.

Test Plan:
- Single op: reset; req0 ADD rs1=5 rs2=7 is_imm=0 tag=3.
  → req0_ready=1 that cycle; next cycle resp_valid=1, data=12, id=0, tag=3.
- Contention: both valid every cycle, resp_ready=1, req0 SUB 10-4 tag=1, req1 XOR 0xF0^0x0F tag=2.
  → responses alternate id 0,1,0,1 (first id=0); data 6 and 0xFF; one result per cycle.
- Backpressure: accept req1 ADD with is_imm=1, rs1=100, imm=0xFFFFFFFF; hold resp_ready=0 for 3 cycles.
  → resp_data=99 stable; both readys=0; once resp_ready=1, the next grant is accepted in that same cycle.
- Priority hold: req1 accepted; 4 idle cycles; then both valid.
  → port 0 granted (last_grant=1 is unchanged by idle cycles).
- Reset mid-flight: accept req0 OR 0x3|0x4, assert rst the next cycle.
  → resp_valid=0, resp_data=0; after reset, contention grants port 0 first.
- Valid withdrawal: req0 valid for 1 cycle while slot is full, then drops.
  → no response with id 0 is ever produced.
